hermes_input_buffer: RTL and testbench
======================================

HERMES_INPUT_BUFFER -- requirements
Module: hermes_input_buffer

Interface
REQ-001 The block SHALL have parameter FLIT_W, default 16, meaning flit width in bits.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 16, meaning FIFO depth in flits (power of two, >=4).
REQ-003 The block SHALL have port clock  input  1  meaning the single clock; all state on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 The block SHALL have port rx  input  1  meaning the upstream flit-valid strobe.
REQ-006 The block SHALL have port data_in  input  FLIT_W  meaning the upstream flit.
REQ-007 The block SHALL have port credit_o  output  1  meaning a free slot is available to upstream.
REQ-008 The block SHALL have port h  output  1  meaning a routing request to switch control for the head flit.
REQ-009 The block SHALL have port ack_h  input  1  meaning switch control granted a route.
REQ-010 The block SHALL have port data_av  output  1  meaning a flit is presented to the crossbar.
REQ-011 The block SHALL have port data  output  FLIT_W  meaning the FIFO head flit.
REQ-012 The block SHALL have port data_ack  input  1  meaning the crossbar consumed the presented flit.
REQ-013 The block SHALL have port sender  output  1  meaning a packet is in transfer through this port.

Function
REQ-014 The block SHALL implement a circular FIFO: credit_o = ~full, combinational; push when rx && credit_o; rx while full is ignored.
REQ-015 The block SHALL pop exactly when data_av && data_ack; data SHALL equal the head flit whenever the FIFO is non-empty.
REQ-016 The block SHALL wrap read/write pointers modulo BUF_DEPTH and keep an occupancy count of $clog2(BUF_DEPTH)+1 bits; a simultaneous push and pop SHALL leave the count unchanged.
REQ-017 The block SHALL treat the packet format as: flit 0 header (target), flit 1 size N (payload flits), then N payload flits.
REQ-018 The FSM SHALL have states IDLE, REQ, SEND_HDR, SEND_SIZE, PAYLOAD, END.
REQ-019 In IDLE the FSM SHALL move to REQ on the edge after the FIFO becomes non-empty.
REQ-020 In REQ the block SHALL drive h=1 and move to SEND_HDR on ack_h; h SHALL be 0 in all other states.
REQ-021 In SEND_HDR the block SHALL drive data_av=1 and move to SEND_SIZE on pop.
REQ-022 In SEND_SIZE and PAYLOAD the block SHALL drive data_av = ~empty.
REQ-023 On the size pop the block SHALL load a payload counter with N and go to END if N==0, else to PAYLOAD.
REQ-024 In PAYLOAD each pop SHALL decrement the counter; a pop with counter==1 SHALL go to END.
REQ-025 END SHALL last exactly one cycle, with data_av=0 and sender=0, then go to IDLE.
REQ-026 sender SHALL be 1 in SEND_HDR, SEND_SIZE and PAYLOAD only.
REQ-027 Outputs h, data_av and sender SHALL be decoded from registered state and FIFO status only, never from ack_h or data_ack in the same cycle.

Reset
REQ-028 While reset_n=0 the block SHALL force FSM=IDLE, pointers=0, count=0, payload counter=0, so that h=0, data_av=0, sender=0, credit_o=1 and data=0.
REQ-029 A reset mid-packet SHALL discard all buffered flits; the first flit after release SHALL be treated as a header.

Configuration
REQ-030 With macro HERMES_IBUF_ERR_CHK_EN defined, the block SHALL add output err_o (1 bit, reset 0), set sticky on rx while full or on a size flit of 0, and cleared only by reset.
REQ-031 Without HERMES_IBUF_ERR_CHK_EN, the block SHALL omit err_o and its logic.

Structure
REQ-032 Package hermes_pkg SHALL hold FLIT_W, the port indices (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4) and the buffer FSM state enum.
REQ-033 The FIFO storage and pointers SHALL live in the sub-module hermes_fifo, instantiated once.

Verification
REQ-034 Packet 0x0011, 0x0002, 0xAAAA, 0xBBBB; ack_h 2 cycles after h; data_ack tied 1 -> 4 pops in order, sender high for 4 cycles, 1 END cycle, then IDLE.
REQ-035 Push 16 flits with data_ack=0 -> credit_o=0 after the 16th push; a 17th rx is dropped (err_o=1 if enabled); one pop -> credit_o=1 next cycle.
REQ-036 Size flit 0x0000 -> END immediately after the size pop; no payload flit is presented.
REQ-037 Full FIFO with simultaneous rx and pop for 20 cycles -> count steady at 15 (push enabled by credit), pointers wrap, data order preserved.
REQ-038 reset_n pulled low during PAYLOAD -> h/data_av/sender=0 and credit_o=1 asynchronously; the next flit pushed after release raises h.

Source files
------------

// File: rtl/hermes_pkg.sv
// Shared definitions for the Hermes router input port: flit width,
// router port indices and the input-buffer packet FSM states.
package hermes_pkg;

  localparam int FLIT_W = 16;

  localparam int EAST  = 0;
  localparam int WEST  = 1;
  localparam int NORTH = 2;
  localparam int SOUTH = 3;
  localparam int LOCAL = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND_HDR,
    ST_SEND_SIZE,
    ST_PAYLOAD,
    ST_END
  } buf_state_t;

endpackage

// File: rtl/hermes_fifo.sv
// Circular flit FIFO for the Hermes input buffer. Writes are ignored when
// full and reads when empty. The head flit is shown combinationally and
// reads as zero while the FIFO is empty.
module hermes_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Flit storage. It is not reset, because only slots behind the pointers
  // are ever read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. The occupancy
  // count holds when a push and a pop happen together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes router input buffer: the flit FIFO plus the packet FSM that asks
// switch control for a route and then streams header, size and payload to
// the crossbar.
// Optional macro HERMES_IBUF_ERR_CHK_EN adds the sticky err_o flag. It is
// set by rx while the FIFO is full or by a size flit of zero.
//
// state        | meaning
// -------------+----------------------------------------------------
// ST_IDLE      | no packet in progress, waiting for a buffered flit
// ST_REQ       | head flit buffered, h raised until ack_h
// ST_SEND_HDR  | header flit presented to the crossbar
// ST_SEND_SIZE | size flit presented, loads payload counter on pop
// ST_PAYLOAD   | payload flits presented, counter decrements per pop
// ST_END       | one idle cycle closing the packet
module hermes_input_buffer
  import hermes_pkg::*;
#(
  parameter int FLIT_W    = hermes_pkg::FLIT_W,
  parameter int BUF_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx,
  input  logic [FLIT_W-1:0] data_in,
  output logic              credit_o,
  output logic              h,
  input  logic              ack_h,
  output logic              data_av,
  output logic [FLIT_W-1:0] data,
  input  logic              data_ack,
  output logic              sender
`ifdef HERMES_IBUF_ERR_CHK_EN
  ,
  output logic              err_o
`endif
);

  buf_state_t        state;
  buf_state_t        state_nxt;
  logic [FLIT_W-1:0] payload_cnt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign credit_o = ~full;
  assign push     = rx && credit_o;
  assign pop      = data_av && data_ack;

  hermes_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (data_in),
    .dout    (data),
    .full    (full),
    .empty   (empty)
  );

  // Packet FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The outputs depend only on the state and the FIFO status. ack_h and
  // data_ack only steer the next state, so they never reach h, data_av or
  // sender in the same cycle.
  always_comb begin
    state_nxt = state;
    h         = 1'b0;
    data_av   = 1'b0;
    sender    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        h = 1'b1;
        if (ack_h) begin
          state_nxt = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        data_av = 1'b1;
        sender  = 1'b1;
        if (data_ack) begin
          state_nxt = ST_SEND_SIZE;
        end
      end
      ST_SEND_SIZE: begin
        data_av = ~empty;
        sender  = 1'b1;
        if (!empty && data_ack) begin
          state_nxt = (data == '0) ? ST_END : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        data_av = ~empty;
        sender  = 1'b1;
        if (!empty && data_ack && payload_cnt == FLIT_W'(1)) begin
          state_nxt = ST_END;
        end
      end
      ST_END: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Payload counter: the size flit loads it when popped, and each payload
  // pop then counts it down.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      payload_cnt <= '0;
    end else if (pop && state == ST_SEND_SIZE) begin
      payload_cnt <= data;
    end else if (pop && state == ST_PAYLOAD) begin
      payload_cnt <= payload_cnt - 1'b1;
    end
  end

`ifdef HERMES_IBUF_ERR_CHK_EN
  // Sticky protocol error flag; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_o <= 1'b0;
    end else if ((rx && full) || (pop && state == ST_SEND_SIZE && data == '0)) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Testbench for hermes_input_buffer. It holds a packet-level reference
// model (a flit queue plus the position in the current packet) and
// compares every output on each falling edge. Directed packets pin the
// model with literal expectations, and a randomized packet stream follows.
module tb_hermes_input_buffer;

  localparam int W = 16;
  localparam int D = 16;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ack_h = 1'b0;
  logic         data_ack = 1'b0;
  logic         credit_o;
  logic         h;
  logic         data_av;
  logic [W-1:0] data;
  logic         sender;
`ifdef HERMES_IBUF_ERR_CHK_EN
  logic         err_o;
`endif

  always #5 clock = ~clock;

  hermes_input_buffer #(.FLIT_W(W), .BUF_DEPTH(D)) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx       (rx),
    .data_in  (data_in),
    .credit_o (credit_o),
    .h        (h),
    .ack_h    (ack_h),
    .data_av  (data_av),
    .data     (data),
    .data_ack (data_ack),
    .sender   (sender)
`ifdef HERMES_IBUF_ERR_CHK_EN
    ,
    .err_o    (err_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffered flits, plus where we are in the packet.
  logic [W-1:0] q[$];
  bit           m_wait;
  bit           m_active;
  bit           m_end;
  bit           m_err;
  int           m_pos;
  int           m_len;
  int           m_h_age;

  logic [W-1:0] pops[$];
  int           sender_cycles;
  logic [W-1:0] src[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_dav();
    return m_active && (m_pos == 0 || q.size() > 0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_wait   = 1'b0;
    m_active = 1'b0;
    m_end    = 1'b0;
    m_err    = 1'b0;
    m_pos    = 0;
    m_len    = 0;
    m_h_age  = 0;
  endtask

  task automatic check_outputs();
    chk("h", 32'(h), 32'(m_wait));
    chk("data_av", 32'(data_av), 32'(exp_dav()));
    chk("sender", 32'(sender), 32'(m_active));
    chk("credit_o", 32'(credit_o), 32'(q.size() < D));
    if (q.size() > 0) chk("data", 32'(data), 32'(q[0]));
`ifdef HERMES_IBUF_ERR_CHK_EN
    chk("err_o", 32'(err_o), 32'(m_err));
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then check on the next negedge.
  task automatic step(input bit i_rx, input logic [W-1:0] i_din, input bit i_ack, input bit i_dack);
    bit do_pop;
    bit do_push;
    rx       = i_rx;
    data_in  = i_din;
    ack_h    = i_ack;
    data_ack = i_dack;
    do_pop   = exp_dav() && i_dack;
    do_push  = i_rx && (q.size() < D);
    if (i_rx && q.size() >= D) m_err = 1'b1;
    if (data_av && i_dack) pops.push_back(data);
    if (sender) sender_cycles++;
    if (m_end) begin
      m_end = 1'b0;
    end else if (m_wait) begin
      if (i_ack) begin
        m_wait   = 1'b0;
        m_active = 1'b1;
        m_pos    = 0;
        m_len    = 0;
      end
    end else if (m_active) begin
      if (do_pop) begin
        if (m_pos == 1) begin
          m_len = int'(q[0]) + 2;
          if (q[0] == '0) m_err = 1'b1;
        end
        m_pos++;
        if (m_pos >= 2 && m_pos == m_len) begin
          m_active = 1'b0;
          m_end    = 1'b1;
        end
      end
    end else if (q.size() > 0) begin
      m_wait = 1'b1;
    end
    if (m_wait) m_h_age++;
    else m_h_age = 0;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(i_din);
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  // Assert reset mid-cycle, check the outputs before any clock edge, then release.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_h", 32'(h), 0);
    chk("rst_data_av", 32'(data_av), 0);
    chk("rst_sender", 32'(sender), 0);
    chk("rst_credit_o", 32'(credit_o), 1);
    chk("rst_data", 32'(data), 0);
`ifdef HERMES_IBUF_ERR_CHK_EN
    chk("rst_err_o", 32'(err_o), 0);
`endif
    rx       = 1'b0;
    ack_h    = 1'b0;
    data_ack = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pkt_a [4];
    bit           size_pop;
    int           sz;
    pkt_a[0] = 16'h0011;
    pkt_a[1] = 16'h0002;
    pkt_a[2] = 16'hAAAA;
    pkt_a[3] = 16'hBBBB;

    model_reset();
    @(negedge clock);
    do_reset();

    // Basic packet with ack_h arriving two cycles after h rises.
    pops.delete();
    sender_cycles = 0;
    for (int i = 0; i < 4; i++) step(1'b1, pkt_a[i], m_wait && m_h_age >= 3, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, m_wait && m_h_age >= 3, 1'b1);
    chk("a_pop_count", 32'(pops.size()), 4);
    for (int i = 0; i < 4 && i < pops.size(); i++) chk("a_pop_data", 32'(pops[i]), 32'(pkt_a[i]));
    chk("a_sender_cycles", 32'(sender_cycles), 4);
    chk("a_idle_h", 32'(h), 0);
    chk("a_idle_sender", 32'(sender), 0);

    // Fill the FIFO with data_ack low, then check the dropped flit and credit return.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    chk("b_credit_full", 32'(credit_o), 0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("b_credit_drop", 32'(credit_o), 0);
`ifdef HERMES_IBUF_ERR_CHK_EN
    chk("b_err_overflow", 32'(err_o), 1);
`endif
    step(1'b0, '0, 1'b1, 1'b0);
    chk("b_hdr_av", 32'(data_av), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("b_credit_back", 32'(credit_o), 1);
    chk("b_next_head", 32'(data), 32'h0101);

    // Zero-size packet: END immediately after the size pop, then the next header.
    do_reset();
    pops.delete();
    step(1'b1, 16'h0022, 1'b0, 1'b1);
    step(1'b1, 16'h0000, m_wait, 1'b1);
    step(1'b1, 16'h0033, m_wait, 1'b1);
    for (int i = 0; i < 10; i++) begin
      size_pop = m_active && m_pos == 1 && exp_dav();
      step(1'b0, '0, m_wait, 1'b1);
      if (size_pop) chk("c_end_after_size", 32'({h, data_av, sender}), 0);
    end
    chk("c_pop_count", 32'(pops.size()), 3);
    if (pops.size() >= 3) begin
      chk("c_pop0", 32'(pops[0]), 32'h0022);
      chk("c_pop1", 32'(pops[1]), 32'h0000);
      chk("c_pop2", 32'(pops[2]), 32'h0033);
    end

    // Full FIFO streaming a long payload while rx keeps pushing.
    do_reset();
    step(1'b1, 16'h0044, 1'b0, 1'b0);
    step(1'b1, 16'd100, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0);
    chk("d_count_full", 32'(u_dut.u_fifo.count), 16);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 16'(16'h6000 + i), 1'b0, 1'b1);
      chk("d_count_steady", 32'(u_dut.u_fifo.count), 15);
    end

    // Reset in the middle of the payload; the next flit is a fresh header.
    chk("e_in_payload", 32'(sender), 1);
    do_reset();
    step(1'b1, 16'h0077, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("e_h_after_reset", 32'(h), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("e_hdr_av", 32'(data_av), 1);
    chk("e_hdr_data", 32'(data), 32'h0077);

    // Randomized packet stream with random handshakes and one mid-run reset.
    do_reset();
    src.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r_rx;
      if (cyc == 1500) begin
        do_reset();
        src.delete();
      end
      if (src.size() < 4) begin
        src.push_back(16'($urandom));
        sz = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 5));
        src.push_back(16'(sz));
        for (int k = 0; k < sz; k++) src.push_back(16'($urandom));
      end
      r_rx = ($urandom_range(0, 9) < 7);
      if (r_rx && q.size() < D) begin
        step(1'b1, src[0], $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 65);
        void'(src.pop_front());
      end else begin
        step(r_rx, src[0], $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 65);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
